mem_arbiter: RTL and testbench

- Arbitrates between instruction fetch (IF) and the load/store unit (LSU), which share one downstream byte-serial memory controller port.
- One transaction is outstanding at a time. The arbiter latches the winning request, issues a one-cycle start pulse downstream, then routes the completion pulse and read data back to the owner.
- LSU has priority. A starvation counter guarantees IF forward progress.
- A pipeline flush cancels IF work; an in-flight fetch is drained and discarded.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_starve_ctr.sv | 34 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/LSU memory arbiter: memory op/length codes,
// arbiter state encodings and the zero-word constant.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_NOP  = 2'd0,
        MEM_LOAD = 2'd1,
        MEM_SAVE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_WORD = 2'd0,
        MEM_HALF = 2'd1,
        MEM_BYTE = 2'd2
    } mem_len_e;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_IF  = 2'd1,
        ARB_WAIT_LSU = 2'd2,
        ARB_DRAIN    = 2'd3
    } arb_state_e;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, LSU and downstream controller signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding cores/controller.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        lsu_req;
    mem_op_e     lsu_op;
    mem_len_e    lsu_len;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;

    logic        dn_start;
    mem_op_e     dn_op;
    mem_len_e    dn_len;
    logic [31:0] dn_addr;
    logic [31:0] dn_wdata;
    logic        dn_done;
    logic [31:0] dn_rdata;

    modport slave (
        input  if_req, if_addr, lsu_req, lsu_op, lsu_len, lsu_addr, lsu_wdata,
               dn_done, dn_rdata,
        output if_done, if_rdata, lsu_done, lsu_rdata,
               dn_start, dn_op, dn_len, dn_addr, dn_wdata
    );

    modport master (
        output if_req, if_addr, lsu_req, lsu_op, lsu_len, lsu_addr, lsu_wdata,
               dn_done, dn_rdata,
        input  if_done, if_rdata, lsu_done, lsu_rdata,
               dn_start, dn_op, dn_len, dn_addr, dn_wdata
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of LSU wins while IF waits; at_limit forces the next IF grant.
module mem_arbiter_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic inc,
    input  logic clr,
    input  logic freeze,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LimitVal = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt;

    assign at_limit = (cnt == LimitVal);

    // Freeze wins over clear so a stalled pipeline leaves the count untouched.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && !at_limit) begin
                cnt <= cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and the LSU in front of a
// shared memory controller; LSU has priority, bounded by a starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           flush_in,
    mem_arbiter_if.slave   bus
);

    arb_state_e state;
    logic       served_if;
    logic       served_lsu;
    logic       at_limit;
    logic       can_grant;
    logic       lsu_valid;
    logic       if_elig;
    logic       lsu_elig;
    logic       grant_if;
    logic       grant_lsu;

    assign can_grant = (state == ARB_IDLE) && rdy_in;
    assign lsu_valid = bus.lsu_req && ((bus.lsu_op == MEM_LOAD) || (bus.lsu_op == MEM_SAVE));
    assign if_elig   = bus.if_req && !flush_in && !served_if;
    assign lsu_elig  = lsu_valid && !served_lsu;
    assign grant_if  = can_grant && if_elig && (!lsu_elig || at_limit);
    assign grant_lsu = can_grant && lsu_elig && !grant_if;

    mem_arbiter_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .inc      (grant_lsu && bus.if_req),
        .clr      (grant_if || flush_in),
        .freeze   (!rdy_in),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= ARB_IDLE;
            served_if     <= 1'b0;
            served_lsu    <= 1'b0;
            bus.dn_start  <= 1'b0;
            bus.if_done   <= 1'b0;
            bus.lsu_done  <= 1'b0;
            bus.dn_op     <= MEM_NOP;
            bus.dn_len    <= MEM_WORD;
            bus.dn_addr   <= ZeroWord;
            bus.dn_wdata  <= ZeroWord;
            bus.if_rdata  <= ZeroWord;
            bus.lsu_rdata <= ZeroWord;
        end else begin
            bus.dn_start <= 1'b0;
            bus.if_done  <= 1'b0;
            bus.lsu_done <= 1'b0;
            case (state)
                // The served mask lasts one IDLE edge, stalled or not.
                ARB_IDLE: begin
                    served_if  <= 1'b0;
                    served_lsu <= 1'b0;
                    if (grant_if) begin
                        bus.dn_start <= 1'b1;
                        bus.dn_op    <= MEM_LOAD;
                        bus.dn_len   <= MEM_WORD;
                        bus.dn_addr  <= bus.if_addr;
                        bus.dn_wdata <= ZeroWord;
                        state        <= ARB_WAIT_IF;
                    end else if (grant_lsu) begin
                        bus.dn_start <= 1'b1;
                        bus.dn_op    <= bus.lsu_op;
                        bus.dn_len   <= bus.lsu_len;
                        bus.dn_addr  <= bus.lsu_addr;
                        bus.dn_wdata <= bus.lsu_wdata;
                        state        <= ARB_WAIT_LSU;
                    end
                end
                ARB_WAIT_IF: begin
                    if (flush_in) begin
                        state <= bus.dn_done ? ARB_IDLE : ARB_DRAIN;
                    end else if (bus.dn_done) begin
                        bus.if_done  <= 1'b1;
                        bus.if_rdata <= bus.dn_rdata;
                        served_if    <= 1'b1;
                        state        <= ARB_IDLE;
                    end
                end
                ARB_WAIT_LSU: begin
                    if (bus.dn_done) begin
                        bus.lsu_done <= 1'b1;
                        if (bus.dn_op == MEM_LOAD) begin
                            bus.lsu_rdata <= bus.dn_rdata;
                        end
                        served_lsu <= 1'b1;
                        state      <= ARB_IDLE;
                    end
                end
                ARB_DRAIN: begin
                    if (bus.dn_done) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for starvation, flush, stall and asynchronous reset corners.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b0;
    logic rdy_in   = 1'b0;
    logic flush_in = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    // ctl = {rdy_in, flush_in, if_req, lsu_req, dn_done}; exp = {dn_start, if_done, lsu_done}
    typedef struct {
        string       name;
        logic [4:0]  ctl;
        logic [31:0] if_addr;
        mem_op_e     op;
        mem_len_e    len;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        logic [31:0] dn_rdata;
        logic [2:0]  exp;
        mem_op_e     e_op;
        mem_len_e    e_len;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(string name, logic [4:0] ctl, logic [31:0] if_addr,
                                 mem_op_e op, mem_len_e len, logic [31:0] lsu_addr,
                                 logic [31:0] lsu_wdata, logic [31:0] dn_rdata,
                                 logic [2:0] exp, mem_op_e e_op, mem_len_e e_len,
                                 logic [31:0] e_addr, logic [31:0] e_wdata,
                                 logic [31:0] e_rdata);
        vec_t v;
        v.name = name; v.ctl = ctl; v.if_addr = if_addr; v.op = op; v.len = len;
        v.lsu_addr = lsu_addr; v.lsu_wdata = lsu_wdata; v.dn_rdata = dn_rdata;
        v.exp = exp; v.e_op = e_op; v.e_len = e_len; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleInputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = ZeroWord;
        bus.lsu_req   = 1'b0;
        bus.lsu_op    = MEM_NOP;
        bus.lsu_len   = MEM_WORD;
        bus.lsu_addr  = ZeroWord;
        bus.lsu_wdata = ZeroWord;
        bus.dn_done   = 1'b0;
        bus.dn_rdata  = ZeroWord;
        flush_in      = 1'b0;
    endtask

    task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        rdy_in        = v.ctl[4];
        flush_in      = v.ctl[3];
        bus.if_req    = v.ctl[2];
        bus.lsu_req   = v.ctl[1];
        bus.dn_done   = v.ctl[0];
        bus.if_addr   = v.if_addr;
        bus.lsu_op    = v.op;
        bus.lsu_len   = v.len;
        bus.lsu_addr  = v.lsu_addr;
        bus.lsu_wdata = v.lsu_wdata;
        bus.dn_rdata  = v.dn_rdata;
        tick();
    endtask

    task automatic checkOutput(vec_t v);
        bit ok;
        vectors++;
        ok = ({bus.dn_start, bus.if_done, bus.lsu_done} === v.exp);
        if (v.exp[2])
            ok = ok && (bus.dn_op === v.e_op) && (bus.dn_len === v.e_len) &&
                 (bus.dn_addr === v.e_addr) && (bus.dn_wdata === v.e_wdata);
        if (v.exp[1]) ok = ok && (bus.if_rdata === v.e_rdata);
        if (v.exp[0]) ok = ok && (bus.lsu_rdata === v.e_rdata);
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got start/ifd/lsud=%b%b%b op=%0d len=%0d addr=%h wdata=%h if_rdata=%h lsu_rdata=%h, required %b op=%0d len=%0d addr=%h wdata=%h rdata=%h",
                     v.name, bus.dn_start, bus.if_done, bus.lsu_done, bus.dn_op, bus.dn_len,
                     bus.dn_addr, bus.dn_wdata, bus.if_rdata, bus.lsu_rdata, v.exp,
                     v.e_op, v.e_len, v.e_addr, v.e_wdata, v.e_rdata);
        end
    endtask

    // dn_done while the arbiter is idle is a controller protocol violation.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            assert (!(dut.state == ARB_IDLE && bus.dn_done))
                else $error("[TB] protocol: dn_done seen while arbiter idle");
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] order [6];
        bit got;
        bit quiet;

        idleInputs();
        #1 rst_in = 1'b1;
        tick();
        tick();
        checkVal("reset_ctrl", 64'({bus.dn_start, bus.if_done, bus.lsu_done, bus.dn_op, bus.dn_len}),
                 64'({3'b000, MEM_NOP, MEM_WORD}));
        checkVal("reset_data", 64'(bus.dn_addr | bus.dn_wdata | bus.if_rdata | bus.lsu_rdata), 64'd0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        tick();

        // LSU word load, controller answers on the fifth cycle
        vq.push_back(mkv("ld_grant", 5'b10010, ZeroWord, MEM_LOAD, MEM_WORD, 32'h100, ZeroWord, ZeroWord, 3'b100, MEM_LOAD, MEM_WORD, 32'h100, ZeroWord, ZeroWord));
        for (int i = 1; i <= 4; i++)
            vq.push_back(mkv($sformatf("ld_wait%0d", i), 5'b10010, ZeroWord, MEM_LOAD, MEM_WORD, 32'h100, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        vq.push_back(mkv("ld_done", 5'b10011, ZeroWord, MEM_LOAD, MEM_WORD, 32'h100, ZeroWord, 32'hDEADBEEF, 3'b001, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, 32'hDEADBEEF));
        vq.push_back(mkv("ld_late_req", 5'b10010, ZeroWord, MEM_LOAD, MEM_WORD, 32'h100, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        vq.push_back(mkv("ld_idle", 5'b10000, ZeroWord, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        // store beats a fetch, then the served mask hands the next slot to IF
        vq.push_back(mkv("st_vs_if", 5'b10110, 32'h300, MEM_SAVE, MEM_HALF, 32'h44, 32'hA5A5, ZeroWord, 3'b100, MEM_SAVE, MEM_HALF, 32'h44, 32'hA5A5, ZeroWord));
        vq.push_back(mkv("st_done", 5'b10111, 32'h300, MEM_SAVE, MEM_HALF, 32'h44, 32'hA5A5, 32'h5555, 3'b001, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, 32'hDEADBEEF));
        vq.push_back(mkv("mask_if_grant", 5'b10110, 32'h300, MEM_SAVE, MEM_HALF, 32'h44, 32'hA5A5, ZeroWord, 3'b100, MEM_LOAD, MEM_WORD, 32'h300, ZeroWord, ZeroWord));
        vq.push_back(mkv("if_done1", 5'b10101, 32'h300, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, 32'h11223344, 3'b010, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, 32'h11223344));
        vq.push_back(mkv("if_late_req", 5'b10100, 32'h300, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        vq.push_back(mkv("idle2", 5'b10000, ZeroWord, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        // stall, flush in IDLE, then a normal fetch and a NOP request
        vq.push_back(mkv("rdy_low_if", 5'b00100, 32'h400, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        vq.push_back(mkv("flush_idle", 5'b11100, 32'h400, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        vq.push_back(mkv("if_after_flush", 5'b10100, 32'h400, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b100, MEM_LOAD, MEM_WORD, 32'h400, ZeroWord, ZeroWord));
        vq.push_back(mkv("if_done2", 5'b10101, 32'h400, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, 32'h77, 3'b010, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, 32'h77));
        vq.push_back(mkv("lsu_nop_req", 5'b10010, ZeroWord, MEM_NOP, MEM_WORD, 32'h88, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));
        vq.push_back(mkv("idle3", 5'b10000, ZeroWord, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord, 3'b000, MEM_NOP, MEM_WORD, ZeroWord, ZeroWord, ZeroWord));

        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            checkOutput(vq[i]);
        end

        // Contention, limit 2: one stalled edge after each completion lets the mask lapse
        idleInputs();
        order = '{32'h500, 32'h500, 32'h600, 32'h500, 32'h500, 32'h600};
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h600;
        bus.lsu_req   = 1'b1;
        bus.lsu_op    = MEM_SAVE;
        bus.lsu_len   = MEM_WORD;
        bus.lsu_addr  = 32'h500;
        bus.lsu_wdata = 32'h5A5A0000;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                if (bus.dn_start) got = 1'b1;
            end
            checkVal($sformatf("contention_grant%0d", g), 64'({got, bus.dn_addr}), 64'({1'b1, order[g]}));
            tick();
            bus.dn_done  = 1'b1;
            bus.dn_rdata = 32'(g);
            tick();
            bus.dn_done = 1'b0;
            rdy_in      = 1'b0;
            tick();
            rdy_in = 1'b1;
        end
        idleInputs();
        tick();

        // Flush while a fetch is in flight; the drained result is dropped
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        tick();
        checkVal("flush_if_grant", 64'({bus.dn_start, bus.dn_addr}), 64'({1'b1, 32'h200}));
        tick();
        flush_in     = 1'b1;
        bus.if_req   = 1'b0;
        bus.lsu_req  = 1'b1;
        bus.lsu_op   = MEM_LOAD;
        bus.lsu_len  = MEM_WORD;
        bus.lsu_addr = 32'h700;
        tick();
        quiet        = !bus.if_done && !bus.dn_start;
        flush_in     = 1'b0;
        bus.dn_done  = 1'b1;
        bus.dn_rdata = 32'h13;
        tick();
        quiet       = quiet && !bus.if_done;
        bus.dn_done = 1'b0;
        checkVal("flush_no_if_done", 64'(quiet), 64'd1);
        tick();
        checkVal("flush_next_lsu", 64'({bus.dn_start, bus.dn_addr}), 64'({1'b1, 32'h700}));
        bus.dn_done  = 1'b1;
        bus.dn_rdata = 32'hABCD;
        tick();
        checkVal("flush_lsu_done", 64'({bus.lsu_done, bus.lsu_rdata}), 64'({1'b1, 32'hABCD}));
        idleInputs();
        tick();

        // Flush and completion on the same edge in WAIT_IF
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h240;
        tick();
        checkVal("simul_if_grant", 64'({bus.dn_start, bus.dn_addr}), 64'({1'b1, 32'h240}));
        flush_in     = 1'b1;
        bus.dn_done  = 1'b1;
        bus.dn_rdata = 32'h99;
        bus.if_req   = 1'b0;
        tick();
        checkVal("simul_flush_done", 64'({bus.if_done, dut.state == ARB_IDLE}), 64'({1'b0, 1'b1}));
        idleInputs();
        quiet = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            quiet = quiet && !bus.dn_start && !bus.if_done;
        end
        checkVal("simul_no_grant", 64'(quiet), 64'd1);

        // rdy_in low across a completion: done forwarded, no new grant
        bus.lsu_req  = 1'b1;
        bus.lsu_op   = MEM_LOAD;
        bus.lsu_len  = MEM_BYTE;
        bus.lsu_addr = 32'h800;
        tick();
        checkVal("stall_lsu_grant", 64'({bus.dn_start, bus.dn_len, bus.dn_addr}), 64'({1'b1, MEM_BYTE, 32'h800}));
        rdy_in = 1'b0;
        tick();
        bus.dn_done  = 1'b1;
        bus.dn_rdata = 32'hCAFE0001;
        tick();
        checkVal("stall_lsu_done", 64'({bus.lsu_done, bus.lsu_rdata}), 64'({1'b1, 32'hCAFE0001}));
        bus.dn_done = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_op  = MEM_NOP;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h900;
        quiet = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            quiet = quiet && !bus.dn_start;
        end
        checkVal("stall_no_grant", 64'(quiet), 64'd1);
        rdy_in = 1'b1;
        tick();
        checkVal("stall_release_grant", 64'({bus.dn_start, bus.dn_addr}), 64'({1'b1, 32'h900}));
        bus.dn_done  = 1'b1;
        bus.dn_rdata = 32'h42;
        tick();
        checkVal("stall_if_done", 64'({bus.if_done, bus.if_rdata}), 64'({1'b1, 32'h42}));
        idleInputs();
        tick();

        // Asynchronous reset in WAIT_LSU, checked between clock edges
        bus.lsu_req   = 1'b1;
        bus.lsu_op    = MEM_SAVE;
        bus.lsu_len   = MEM_WORD;
        bus.lsu_addr  = 32'h1000;
        bus.lsu_wdata = 32'hFFFF0000;
        tick();
        checkVal("rst_pre_grant", 64'({bus.dn_start, bus.dn_addr}), 64'({1'b1, 32'h1000}));
        tick();
        #2 rst_in = 1'b1;
        #1;
        checkVal("rst_async_ctrl", 64'({bus.dn_start, bus.if_done, bus.lsu_done, bus.dn_op, bus.dn_len}),
                 64'({3'b000, MEM_NOP, MEM_WORD}));
        checkVal("rst_async_addr", 64'(bus.dn_addr), 64'd0);
        checkVal("rst_async_wdata", 64'(bus.dn_wdata), 64'd0);
        checkVal("rst_async_rdata", 64'({bus.if_rdata, bus.lsu_rdata}), 64'd0);
        checkVal("rst_async_state", 64'(dut.state == ARB_IDLE), 64'd1);
        idleInputs();
        #2 rst_in = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
